// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: the transmit end of a single-bit serial link.
// Optional even-parity trailer bit when the PISO_PARITY_EN macro is defined.
module piso_shift_reg #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             done_r, done_s;
`ifdef PISO_PARITY_EN
  logic             parity_r, parity_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // Vacated positions are back-filled with the idle level.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], IDLE_LEVEL};
    end else begin
      return {IDLE_LEVEL, w[WIDTH-1:1]};
    end
  endfunction

  // Next-state logic: capture, shift and frame-end detection.
  always_comb begin
    state_s  = state_r;
    shreg_s  = shreg_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (load_valid) begin
          state_s  = ST_SHIFT;
          shreg_s  = din;
          cnt_s    = {CNT_W{1'b0}};
`ifdef PISO_PARITY_EN
          parity_s = even_parity(din);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          shreg_s = shift_once(shreg_r);
          cnt_s   = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_DATA) begin
`ifdef PISO_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_IDLE;
            done_s  = 1'b1;
`endif
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (shift_en) begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      shreg_r  <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      done_r   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      shreg_r  <= shreg_s;
      cnt_r    <= cnt_s;
      done_r   <= done_s;
`ifdef PISO_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  // Serial bit selection: head of the register, parity trailer, or idle level.
  always_comb begin
    sout = IDLE_LEVEL;
    case (state_r)
      ST_SHIFT: begin
        sout = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        sout = parity_r;
      end
`endif
      default: begin
        sout = IDLE_LEVEL;
      end
    endcase
  end

  assign load_ready = (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);
  assign sout_valid = (state_r != ST_IDLE);
  assign done       = done_r;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: an MSB-first and an LSB-first instance share all inputs.
module tb_piso_shift_reg;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = 8 + (PAR ? 1 : 0);

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] din;
  logic       shift_en;

  logic load_ready_m, sout_m, sout_valid_m, busy_m, done_m;
  logic load_ready_l, sout_l, sout_valid_l, busy_l, done_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_m),
    .din(din), .shift_en(shift_en), .sout(sout_m), .sout_valid(sout_valid_m),
    .busy(busy_m), .done(done_m)
  );

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_l),
    .din(din), .shift_en(shift_en), .sout(sout_l), .sout_valid(sout_valid_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a whole frame in progress with shift_en held high; inj_k >= 0 injects a load at that bit.
  task automatic run_frame(input logic [7:0] w, input int inj_k);
    logic em, el;
    shift_en = 1'b1;
    for (int k = 0; k < FL; k++) begin
      em = (k < 8) ? w[7-k] : ^w;
      el = (k < 8) ? w[k]   : ^w;
      if (k == inj_k) begin
        load_valid = 1'b1;
        din        = 8'hFF;
        chk("load_ready_busy", load_ready_m, 1'b0);
      end else begin
        load_valid = 1'b0;
      end
      chk("sout_msb", sout_m, em);
      chk("sout_lsb", sout_l, el);
      chk("busy_mid", busy_m, 1'b1);
      chk("done_mid", done_m, 1'b0);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic check_done();
    chk("done_pulse_m", done_m, 1'b1);
    chk("done_pulse_l", done_l, 1'b1);
    chk("ready_done", load_ready_m, 1'b1);
    chk("busy_done", busy_m, 1'b0);
    chk("sout_valid_done", sout_valid_m, 1'b0);
    chk("sout_idle", sout_m, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    logic       eb;

    // Reset
    rst = 1'b1; load_valid = 1'b0; din = 8'h00; shift_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sout", sout_m, 1'b0);
    chk("rst_sout_valid", sout_valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_done", done_m, 1'b0);
    chk("rst_ready", load_ready_m, 1'b1);
    chk("rst_ready_l", load_ready_l, 1'b1);

    // shift_en alone in IDLE is ignored
    shift_en = 1'b1;
    tick();
    chk("idle_shift_busy", busy_m, 1'b0);

    // MSB-first A5 with load and shift_en together (shift not counted)
    din = 8'hA5; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    din = 8'h00;
    run_frame(8'hA5, -1);
    check_done();
    shift_en = 1'b0;
    tick();
    chk("done_one_cycle", done_m, 1'b0);

    // Slow bit rate: shift_en every 4th cycle, LSB-first instance checked
    w = 8'h01;
    din = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; din = 8'hFF;
    for (int k = 0; k < FL; k++) begin
      eb = (k < 8) ? w[k] : ^w;
      for (int c = 0; c < 4; c++) begin
        chk("slow_sout_l", sout_l, eb);
        chk("slow_done_l", done_l, 1'b0);
        shift_en = (c == 3);
        tick();
      end
    end
    shift_en = 1'b0;
    chk("slow_done_pulse", done_l, 1'b1);
    chk("slow_ready", load_ready_l, 1'b1);
    tick();
    chk("slow_done_clear", done_l, 1'b0);

    // Load while busy is ignored
    din = 8'h3C; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    run_frame(8'h3C, 2);
    check_done();
    shift_en = 1'b0;
    tick();

    // Reset mid-frame after 3 consumed bits
    din = 8'hF0; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_busy", busy_m, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_done", done_m, 1'b0);
    chk("abort_sout", sout_m, 1'b0);
    chk("abort_ready", load_ready_m, 1'b1);
    tick();
    chk("abort_no_done", done_m, 1'b0);

    // Back-to-back frames: second load accepted in the done cycle
    din = 8'h81; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    run_frame(8'h81, -1);
    check_done();
    din = 8'h7E; load_valid = 1'b1;
    tick();
    din = 8'h00;
    chk("b2b_busy", busy_m, 1'b1);
    chk("b2b_done_clear", done_m, 1'b0);
    run_frame(8'h7E, -1);
    check_done();
    shift_en = 1'b0;
    tick();

    // Parity frame: 07 has odd weight so the trailer is 1 when enabled
    w = 8'h07;
    din = w; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("par_data_m", sout_m, w[7-k]);
      tick();
    end
    if (PAR) begin
      chk("par_bit_m", sout_m, 1'b1);
      chk("par_bit_l", sout_l, 1'b1);
      chk("par_busy", busy_m, 1'b1);
      chk("par_not_done", done_m, 1'b0);
      tick();
    end else begin
      chk("nopar_ready", load_ready_m, 1'b1);
    end
    check_done();
    shift_en = 1'b0;
    tick();
    chk("end_idle_done", done_m, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
